// File: rtl/bp_be_dcache_pkg.sv
// bp_be_dcache_pkg: shared types and constants for the dcache LCE response scheduler.
package bp_be_dcache_pkg;
  typedef enum logic {e_resp_src_req, e_resp_src_cmd} bp_be_dcache_resp_src_e;
  localparam int bp_be_dcache_starve_cnt_width_gp = 4;
endpackage

// File: rtl/bp_be_dcache_resp_buf.sv
// bp_be_dcache_resp_buf: 2-entry FIFO with async active-low reset; enq_ready depends on registered count only.
module bp_be_dcache_resp_buf #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               enq_i,
  output logic               enq_ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               deq_i
);
  logic [width_p-1:0] mem [2];
  logic rd_ptr, wr_ptr;
  logic [1:0] count;
  logic enq, deq;
  assign enq_ready_o = (count != 2'd2);
  assign v_o = (count != 2'd0);
  assign data_o = mem[rd_ptr];
  assign enq = enq_i & enq_ready_o;
  assign deq = deq_i & v_o;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= data_i;
        wr_ptr <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      count <= count + 2'(enq) - 2'(deq);
    end
  end
endmodule

// File: rtl/bp_be_dcache_lce_resp_sched.sv
// bp_be_dcache_lce_resp_sched: req-priority arbiter with starvation override feeding a 2-entry response buffer.
// Optional grant statistics counters under BP_BE_DCACHE_RESP_SCHED_STATS_EN.
module bp_be_dcache_lce_resp_sched
  import bp_be_dcache_pkg::*;
#(
  parameter int resp_width_p   = 64,
  parameter int starve_limit_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [resp_width_p-1:0] req_resp_i,
  input  logic                    req_resp_v_i,
  output logic                    req_resp_yumi_o,
  input  logic [resp_width_p-1:0] cmd_resp_i,
  input  logic                    cmd_resp_v_i,
  output logic                    cmd_resp_yumi_o,
  output logic [resp_width_p-1:0] lce_resp_o,
  output logic                    lce_resp_v_o,
  input  logic                    lce_resp_ready_i,
  output logic                    starved_o
`ifdef BP_BE_DCACHE_RESP_SCHED_STATS_EN
  ,
  output logic [31:0]             req_grants_o,
  output logic [31:0]             cmd_grants_o,
  output logic [31:0]             override_grants_o
`endif
);
  localparam logic [bp_be_dcache_starve_cnt_width_gp-1:0] limit_lp =
    bp_be_dcache_starve_cnt_width_gp'(starve_limit_p);
  logic [bp_be_dcache_starve_cnt_width_gp-1:0] starve_cnt;
  logic enq_ready, grant_ok, override;
  bp_be_dcache_resp_src_e src;
  // Grants are held off while in reset so producers never see a yumi that is then discarded.
  assign grant_ok = enq_ready & reset_n_i;
  assign override = (starve_cnt == limit_lp) & cmd_resp_v_i;
  assign src = (override | ~req_resp_v_i) ? e_resp_src_cmd : e_resp_src_req;
  assign req_resp_yumi_o = grant_ok & req_resp_v_i & (src == e_resp_src_req);
  assign cmd_resp_yumi_o = grant_ok & cmd_resp_v_i & (src == e_resp_src_cmd);
  assign starved_o = override;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) starve_cnt <= '0;
    else if (cmd_resp_yumi_o | ~cmd_resp_v_i) starve_cnt <= '0;
    else if (req_resp_yumi_o && starve_cnt != limit_lp) starve_cnt <= starve_cnt + 1'b1;
  end
  bp_be_dcache_resp_buf #(.width_p(resp_width_p)) buffer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .data_i     ((src == e_resp_src_cmd) ? cmd_resp_i : req_resp_i),
    .enq_i      (req_resp_yumi_o | cmd_resp_yumi_o),
    .enq_ready_o(enq_ready),
    .data_o     (lce_resp_o),
    .v_o        (lce_resp_v_o),
    .deq_i      (lce_resp_ready_i)
  );
`ifdef BP_BE_DCACHE_RESP_SCHED_STATS_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_grants_o      <= '0;
      cmd_grants_o      <= '0;
      override_grants_o <= '0;
    end else begin
      if (req_resp_yumi_o && req_grants_o != '1) req_grants_o <= req_grants_o + 1'b1;
      if (cmd_resp_yumi_o && cmd_grants_o != '1) cmd_grants_o <= cmd_grants_o + 1'b1;
      if (cmd_resp_yumi_o && override && override_grants_o != '1) override_grants_o <= override_grants_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_bp_be_dcache_lce_resp_sched.sv
// tb_bp_be_dcache_lce_resp_sched: randomized bench against a queue-based reference model.
module tb_bp_be_dcache_lce_resp_sched;
  localparam int lim = 4;
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_n_i;
  logic [63:0] req_resp_i, cmd_resp_i, lce_resp_o;
  logic req_resp_v_i, cmd_resp_v_i, lce_resp_ready_i;
  logic req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o;
`ifdef BP_BE_DCACHE_RESP_SCHED_STATS_EN
  logic [31:0] req_grants_o, cmd_grants_o, override_grants_o;
`endif
  bp_be_dcache_lce_resp_sched #(.resp_width_p(64), .starve_limit_p(lim)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_resp_i(req_resp_i), .req_resp_v_i(req_resp_v_i), .req_resp_yumi_o(req_resp_yumi_o),
    .cmd_resp_i(cmd_resp_i), .cmd_resp_v_i(cmd_resp_v_i), .cmd_resp_yumi_o(cmd_resp_yumi_o),
    .lce_resp_o(lce_resp_o), .lce_resp_v_o(lce_resp_v_o), .lce_resp_ready_i(lce_resp_ready_i),
    .starved_o(starved_o)
`ifdef BP_BE_DCACHE_RESP_SCHED_STATS_EN
    , .req_grants_o(req_grants_o), .cmd_grants_o(cmd_grants_o), .override_grants_o(override_grants_o)
`endif
  );

  // Reference model: FIFO contents, req grants suffered by a waiting cmd, grant tallies.
  logic [63:0] q[$];
  int waited, n_req, n_cmd, n_ov, tests, fails;

  function automatic logic exp_ov();
    return (waited == lim) && cmd_resp_v_i;
  endfunction

  // {req_yumi, cmd_yumi}
  function automatic logic [1:0] exp_grant();
    if (q.size() == 2) return 2'b00;
    if (exp_ov()) return 2'b01;
    if (req_resp_v_i) return 2'b10;
    return {1'b0, cmd_resp_v_i};
  endfunction

  task automatic drive(input logic rv, input logic cv, input logic rdy);
    @(negedge clk_i);
    req_resp_v_i = rv;
    cmd_resp_v_i = cv;
    lce_resp_ready_i = rdy;
    req_resp_i = {$urandom, $urandom};
    cmd_resp_i = {$urandom, $urandom};
    #1;
  endtask

  task automatic tick();
    logic [1:0] g;
    logic ov, pop;
    g = exp_grant();
    ov = exp_ov();
    pop = (q.size() != 0) && lce_resp_ready_i;
    @(posedge clk_i);
    if (pop) void'(q.pop_front());
    if (g[1]) q.push_back(req_resp_i);
    if (g[0]) q.push_back(cmd_resp_i);
    if (g[0] || !cmd_resp_v_i) waited = 0;
    else if (g[1]) waited = (waited < lim) ? waited + 1 : lim;
    n_req += int'(g[1]);
    n_cmd += int'(g[0]);
    n_ov += int'(g[0] && ov);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    req_resp_v_i = 1'b0;
    cmd_resp_v_i = 1'b0;
    lce_resp_ready_i = 1'b1;
    q.delete();
    waited = 0; n_req = 0; n_cmd = 0; n_ov = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] a;
    @(negedge clk_i);
    req_resp_v_i = 1'b1;
    cmd_resp_v_i = 1'b1;
    lce_resp_ready_i = 1'b1;
    reset_n_i = 1'b0;
    #1;
    tests++;
    if ({req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o, lce_resp_o} !== 68'd0) begin
      fails++;
      $display("FAIL reset_outputs got %b %b %b %b %h want all zero", req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o, lce_resp_o);
    end
    q.delete();
    waited = 0; n_req = 0; n_cmd = 0; n_ov = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    req_resp_i = {$urandom, $urandom};
    a = req_resp_i;
    #1;
    tests++;
    if ({req_resp_yumi_o, cmd_resp_yumi_o} !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_grant got %b want 10", {req_resp_yumi_o, cmd_resp_yumi_o});
    end
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if (lce_resp_v_o !== 1'b1 || lce_resp_o !== a) begin
      fails++;
      $display("FAIL reset_first_resp got v=%b %h want v=1 %h", lce_resp_v_o, lce_resp_o, a);
    end
    tick();
  endtask

  task automatic test_pattern();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      tests++;
      if ({req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o} !== {exp_grant(), q.size() != 0, exp_ov()}
          || (q.size() != 0 && lce_resp_o !== q[0])) begin
        fails++;
        $display("FAIL pattern_model cyc %0d got %b %h want %b", i, {req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o}, lce_resp_o, {exp_grant(), q.size() != 0, exp_ov()});
      end
      tests++;
      if ({cmd_resp_yumi_o, starved_o} !== {2{i % 5 == 4}}) begin
        fails++;
        $display("FAIL pattern_rrrrc cyc %0d got cmd_yumi=%b starved=%b want %b", i, cmd_resp_yumi_o, starved_o, i % 5 == 4);
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic [63:0] exp_a, exp_b;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tests++;
      if ({req_resp_yumi_o, cmd_resp_yumi_o, starved_o} !== {exp_grant(), exp_ov()} || {req_resp_yumi_o, cmd_resp_yumi_o} !== {i < 2, 1'b0}) begin
        fails++;
        $display("FAIL full_grant cyc %0d got %b%b%b want %b", i, req_resp_yumi_o, cmd_resp_yumi_o, starved_o, {exp_grant(), exp_ov()});
      end
      tick();
    end
    exp_a = q[0];
    exp_b = q[1];
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if (lce_resp_v_o !== 1'b1 || lce_resp_o !== exp_a) begin
      fails++;
      $display("FAIL full_drain_a got v=%b %h want %h", lce_resp_v_o, lce_resp_o, exp_a);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if (lce_resp_v_o !== 1'b1 || lce_resp_o !== exp_b) begin
      fails++;
      $display("FAIL full_drain_b got v=%b %h want %h", lce_resp_v_o, lce_resp_o, exp_b);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if (lce_resp_v_o !== 1'b0) begin
      fails++;
      $display("FAIL full_empty got v=%b want 0", lce_resp_v_o);
    end
    tick();
  endtask

  task automatic test_cmd_only();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      tests++;
      if ({req_resp_yumi_o, cmd_resp_yumi_o, starved_o} !== 3'b010 || lce_resp_v_o !== (i != 0)
          || (q.size() != 0 && lce_resp_o !== q[0])) begin
        fails++;
        $display("FAIL cmd_only cyc %0d got %b%b%b v=%b %h", i, req_resp_yumi_o, cmd_resp_yumi_o, starved_o, lce_resp_v_o, lce_resp_o);
      end
      tick();
    end
  endtask

  task automatic test_starve_clear();
    logic [0:8] cv_seq;
    logic [0:8] cmd_seq;
    do_reset();
    cv_seq  = 9'b111011111;
    cmd_seq = 9'b000000001;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, cv_seq[i], 1'b1);
      tests++;
      if (cmd_resp_yumi_o !== cmd_seq[i] || req_resp_yumi_o !== !cmd_seq[i] || starved_o !== exp_ov()) begin
        fails++;
        $display("FAIL starve_clear cyc %0d got cmd=%b req=%b starved=%b want cmd=%b", i, cmd_resp_yumi_o, req_resp_yumi_o, starved_o, cmd_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
      tests++;
      if ({req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o} !== {exp_grant(), q.size() != 0, exp_ov()}
          || (q.size() != 0 && lce_resp_o !== q[0])) begin
        fails++;
        $display("FAIL random cyc %0d got %b %h want %b", i, {req_resp_yumi_o, cmd_resp_yumi_o, lce_resp_v_o, starved_o}, lce_resp_o, {exp_grant(), q.size() != 0, exp_ov()});
      end
      tick();
    end
  endtask

`ifdef BP_BE_DCACHE_RESP_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b1);
    tests++;
    if ({req_grants_o, cmd_grants_o, override_grants_o} !== {32'd8, 32'd2, 32'd2}
        || {n_req, n_cmd, n_ov} !== {32'd8, 32'd2, 32'd2}) begin
      fails++;
      $display("FAIL stats got %0d %0d %0d want 8 2 2", req_grants_o, cmd_grants_o, override_grants_o);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    reset_n_i = 1'b0;
    req_resp_v_i = 1'b0;
    cmd_resp_v_i = 1'b0;
    lce_resp_ready_i = 1'b0;
    req_resp_i = '0;
    cmd_resp_i = '0;
    test_reset();
    test_pattern();
    test_full();
    test_cmd_only();
    test_starve_clear();
    test_random();
`ifdef BP_BE_DCACHE_RESP_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
